// File: rtl/regfile_write_arbiter.sv
// Register-file write port D arbiter: the pipeline writeback has priority, and aux results wait in a 2-entry FIFO.
// Optional build macro WB_ARB_STARVE_EN adds an IDLE/WAIT/FORCE starvation FSM that drives pipe_stall.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_is_dest_special,
  input  logic [4:0]  pipe_dest,
  input  logic [31:0] pipe_result,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic        aux_is_dest_special,
  input  logic [4:0]  aux_dest,
  input  logic [31:0] aux_result,
  output logic        pipe_stall,
  output logic        portD_enable,
  output logic [4:0]  portD_key,
  output logic [31:0] portD_value
);

  typedef struct packed {
    logic        special;
    logic [4:0]  dest;
    logic [31:0] result;
  } wb_req_t;

  // Key 0 is the special register; a plain write to x0 is dropped.
  function automatic logic is_effective(input logic special, input logic [4:0] dest);
    return special ? (dest == 5'd0) : (dest != 5'd0);
  endfunction

  wb_req_t     fifo_q [2];
  wb_req_t     head;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        portD_enable_q, portD_enable_d;
  logic [4:0]  portD_key_q, portD_key_d;
  logic [31:0] portD_value_q, portD_value_d;
  logic        pipe_win, push, pop;

  assign head      = fifo_q[rd_ptr_q];
  assign aux_ready = (count_q != 2'd2);
  assign pipe_win  = pipe_valid && is_effective(pipe_is_dest_special, pipe_dest);
  assign push      = aux_valid && aux_ready;
  assign pop       = (count_q != 2'd0) && !pipe_win;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {aux_is_dest_special, aux_dest, aux_result};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Grant stage: key/value follow the granted source, hold when nothing is granted.
  always_comb begin
    portD_enable_d = 1'b0;
    portD_key_d    = portD_key_q;
    portD_value_d  = portD_value_q;
    if (pipe_win) begin
      portD_enable_d = 1'b1;
      portD_key_d    = pipe_dest;
      portD_value_d  = pipe_result;
    end else if (pop) begin
      portD_enable_d = is_effective(head.special, head.dest);
      portD_key_d    = head.dest;
      portD_value_d  = head.result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      portD_enable_q <= 1'b0;
      portD_key_q    <= 5'd0;
      portD_value_q  <= 32'd0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      portD_enable_q <= portD_enable_d;
      portD_key_q    <= portD_key_d;
      portD_value_q  <= portD_value_d;
    end
  end

  assign portD_enable = portD_enable_q;
  assign portD_key    = portD_key_q;
  assign portD_value  = portD_value_q;

`ifdef WB_ARB_STARVE_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} starve_state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  starve_state_e state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          pipe_stall_q, pipe_stall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 8'd0;
      pipe_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (push) begin
          state_d    = S_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      S_WAIT, S_FORCE: begin
        if (pop) begin
          wait_cnt_d = 8'd0;
          state_d    = (count_d != 2'd0) ? S_WAIT : S_IDLE;
        end else begin
          wait_cnt_d = sat_inc(wait_cnt_q);
          if (state_q == S_WAIT && wait_cnt_q == WAIT_LAST) state_d = S_FORCE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bubble request is registered so it is high exactly while the FSM sits in FORCE.
  always_comb begin
    pipe_stall_d = (state_d == S_FORCE);
  end

  assign pipe_stall = pipe_stall_q;
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign pipe_stall      = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: scoreboard of expected port-D writes plus per-cycle timing checks.
module tb_regfile_write_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_is_dest_special;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_result;
  logic        aux_valid, aux_ready, aux_is_dest_special;
  logic [4:0]  aux_dest;
  logic [31:0] aux_result;
  logic        pipe_stall, portD_enable;
  logic [4:0]  portD_key;
  logic [31:0] portD_value;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [36:0] sb_q [$];
  logic [36:0] exp_wr;
  logic        starve_on;

  regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_is_dest_special(pipe_is_dest_special),
    .pipe_dest(pipe_dest), .pipe_result(pipe_result),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_is_dest_special(aux_is_dest_special), .aux_dest(aux_dest), .aux_result(aux_result),
    .pipe_stall(pipe_stall), .portD_enable(portD_enable),
    .portD_key(portD_key), .portD_value(portD_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic sp, input logic [4:0] d, input logic [31:0] r);
    pipe_valid = v; pipe_is_dest_special = sp; pipe_dest = d; pipe_result = r;
  endtask

  task automatic drive_aux(input logic v, input logic sp, input logic [4:0] d, input logic [31:0] r);
    aux_valid = v; aux_is_dest_special = sp; aux_dest = d; aux_result = r;
  endtask

  task automatic expect_wr(input logic [4:0] k, input logic [31:0] v);
    sb_q.push_back({k, v});
  endtask

  // Every write reaching the register file must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && portD_enable) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wr", 64'(portD_enable), 64'd0);
      end else begin
        exp_wr = sb_q.pop_front();
        check("sb_wr", 64'({portD_key, portD_value}), 64'(exp_wr));
      end
    end
  end

  initial begin
`ifdef WB_ARB_STARVE_EN
    starve_on = 1'b1;
`else
    starve_on = 1'b0;
`endif
    reset = 1'b1;
    drive_pipe(0, 0, 5'd0, 32'd0);
    drive_aux(0, 0, 5'd0, 32'd0);
    tick(); tick();
    check("rst_en",    64'(portD_enable), 64'd0);
    check("rst_key",   64'(portD_key),    64'd0);
    check("rst_val",   64'(portD_value),  64'd0);
    check("rst_stall", 64'(pipe_stall),   64'd0);
    check("rst_ready", 64'(aux_ready),    64'd1);
    reset = 1'b0;

    // Pipe-only writes, including the dropped x0 write.
    drive_pipe(1, 0, 5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    check("pipe_en",  64'(portD_enable), 64'd1);
    check("pipe_val", 64'(portD_value),  64'hDEADBEEF);
    drive_pipe(1, 0, 5'd0, 32'h1111);
    tick();
    check("pipe_x0_en",  64'(portD_enable), 64'd0);
    check("pipe_x0_key", 64'(portD_key),    64'd5);

    // Special register writes; a non-effective special lets the aux head through.
    drive_pipe(1, 1, 5'd0, 32'h80); expect_wr(5'd0, 32'h80);
    tick();
    check("spec_en",  64'(portD_enable), 64'd1);
    check("spec_key", 64'(portD_key),    64'd0);
    drive_pipe(1, 0, 5'd7, 32'h700); expect_wr(5'd7, 32'h700);
    drive_aux(1, 0, 5'd9, 32'h900);
    tick();
    check("spec_q_key", 64'(portD_key), 64'd7);
    drive_pipe(1, 1, 5'd3, 32'h333); expect_wr(5'd9, 32'h900);
    drive_aux(0, 0, 5'd0, 32'd0);
    tick();
    check("spec3_aux_en",  64'(portD_enable), 64'd1);
    check("spec3_aux_key", 64'(portD_key),    64'd9);

    // FIFO fill with pipe busy, then drain in order with a push/pop at count 1.
    drive_pipe(1, 0, 5'd1, 32'hA000); expect_wr(5'd1, 32'hA000);
    drive_aux(1, 0, 5'd11, 32'hB000);
    tick();
    check("fifo_rdy0", 64'(aux_ready), 64'd1);
    drive_pipe(1, 0, 5'd2, 32'hA001); expect_wr(5'd2, 32'hA001);
    drive_aux(1, 0, 5'd12, 32'hB001);
    tick();
    check("fifo_rdy1", 64'(aux_ready), 64'd0);
    drive_pipe(1, 0, 5'd3, 32'hA002); expect_wr(5'd3, 32'hA002);
    drive_aux(1, 0, 5'd13, 32'hB002);
    tick();
    check("fifo_rdy2", 64'(aux_ready), 64'd0);
    check("fifo_p2",   64'(portD_key), 64'd3);
    drive_pipe(0, 0, 5'd0, 32'd0); expect_wr(5'd11, 32'hB000);
    tick();
    check("fifo_a0",   64'(portD_key), 64'd11);
    check("fifo_rdy3", 64'(aux_ready), 64'd1);
    expect_wr(5'd12, 32'hB001);
    tick();
    check("fifo_a1",   64'(portD_key), 64'd12);
    check("fifo_pp_rdy", 64'(aux_ready), 64'd1);
    drive_aux(0, 0, 5'd0, 32'd0); expect_wr(5'd13, 32'hB002);
    tick();
    check("fifo_a2", 64'({portD_key, portD_value}), 64'({5'd13, 32'hB002}));
    tick();
    check("fifo_idle_en", 64'(portD_enable), 64'd0);

    // Non-effective aux head: popped with enable low, key/value still follow it.
    drive_aux(1, 1, 5'd4, 32'h44);
    tick();
    drive_aux(0, 0, 5'd0, 32'd0);
    tick();
    check("auxne_en",  64'(portD_enable), 64'd0);
    check("auxne_key", 64'({portD_key, portD_value}), 64'({5'd4, 32'h44}));
    check("auxne_rdy", 64'(aux_ready), 64'd1);

    // Starvation: one aux entry under a continuously busy pipe.
    drive_pipe(1, 0, 5'd1, 32'hC001); expect_wr(5'd1, 32'hC001);
    drive_aux(1, 0, 5'd20, 32'h5151);
    tick();
    drive_aux(0, 0, 5'd0, 32'd0);
    check("starve_1", 64'(pipe_stall), 64'd0);
    for (int i = 2; i <= 10; i++) begin
      drive_pipe(1, 0, 5'(i), 32'hC000 + 32'(i)); expect_wr(5'(i), 32'hC000 + 32'(i));
      tick();
      check($sformatf("starve_%0d", i), 64'(pipe_stall), 64'(starve_on && i >= 9));
    end
    drive_pipe(0, 0, 5'd0, 32'd0); expect_wr(5'd20, 32'h5151);
    tick();
    check("starve_aux_key", 64'(portD_key),  64'd20);
    check("starve_drop",    64'(pipe_stall), 64'd0);

    // Reset mid-operation with two aux entries queued.
    drive_pipe(1, 0, 5'd1, 32'hD001); expect_wr(5'd1, 32'hD001);
    drive_aux(1, 0, 5'd21, 32'hE001);
    tick();
    drive_pipe(1, 0, 5'd2, 32'hD002); expect_wr(5'd2, 32'hD002);
    drive_aux(1, 0, 5'd22, 32'hE002);
    tick();
    drive_aux(0, 0, 5'd0, 32'd0);
    for (int i = 3; i <= 10; i++) begin
      drive_pipe(1, 0, 5'(i), 32'hD000 + 32'(i)); expect_wr(5'(i), 32'hD000 + 32'(i));
      tick();
    end
    check("pre_rst_stall", 64'(pipe_stall), 64'(starve_on));
    check("pre_rst_ready", 64'(aux_ready),  64'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    drive_pipe(0, 0, 5'd0, 32'd0);
    #1;
    check("arst_en",    64'(portD_enable), 64'd0);
    check("arst_key",   64'(portD_key),    64'd0);
    check("arst_val",   64'(portD_value),  64'd0);
    check("arst_stall", 64'(pipe_stall),   64'd0);
    check("arst_ready", 64'(aux_ready),    64'd1);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_en_%0d", i), 64'(portD_enable), 64'd0);
      check($sformatf("post_rst_rdy_%0d", i), 64'(aux_ready), 64'd1);
    end
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register-file write port D between the in-order pipeline writeback and an auxiliary multi-cycle unit (load/divide return path). The in-order pipeline has priority. Auxiliary results queue in a 2-entry FIFO, and an optional anti-starvation counter requests a pipeline bubble. The block applies the x0/special-register write-enable rule to both sources and drives registered portD outputs straight into the register file.

## Interface
Parameters:
- MAX_WAIT, 8, cycles an aux entry may wait at FIFO head before a bubble is requested (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pipe_valid  in  1  pipeline writeback request this cycle (cannot be back-pressured)
- pipe_is_dest_special  in  1  destination is the special register mapped on key 0
- pipe_dest  in  5  destination register
- pipe_result  in  32  write data
- aux_valid  in  1  aux unit offers a result
- aux_ready  out  1  FIFO can accept; transfer when aux_valid && aux_ready
- aux_is_dest_special  in  1  as pipe_is_dest_special
- aux_dest  in  5  destination register
- aux_result  in  32  write data
- pipe_stall  out  1  registered request for upstream to insert one writeback bubble
- portD_enable  out  1  register-file write enable
- portD_key  out  5  register-file write address
- portD_value  out  32  register-file write data

## Operation
- Effective write of a request: is_dest_special && dest==0, or !is_dest_special && dest!=0. Otherwise the request is discarded.
- Pipe wins whenever pipe_valid is high and its request is effective.
- A non-effective pipe request does not occupy the port. The aux head may use that cycle.
- Aux FIFO: 2 entries, in-order, tracked by a count of 0..2.
  - aux_ready = (count<2). There is no same-cycle pass-through when full.
  - Push and pop may occur in the same cycle.
- Aux head pop: when the FIFO is non-empty and the pipe does not win, pop the head.
  - If the head is effective, write it to port D.
  - If the head is non-effective, pop it with portD_enable=0. It still consumes the slot.
- Arriving aux data is pushed only. It is never granted in its arrival cycle. Minimum aux latency is push cycle +2 to portD.
- Starvation FSM, states IDLE, WAIT, FORCE:
  - IDLE → WAIT when FIFO becomes non-empty. wait_cnt=0.
  - WAIT: wait_cnt increments each cycle the head is not popped.
    - On a pop, wait_cnt clears. Stay in WAIT if entries remain, else go to IDLE.
    - wait_cnt==MAX_WAIT-1 with no pop → FORCE.
  - FORCE: pipe_stall=1.
    - Pipe still wins if pipe_valid is effective; the upstream bubble is advisory.
    - On the first aux pop, go to WAIT (entries remain) or IDLE, and pipe_stall drops next cycle.
  - wait_cnt saturates and never wraps.
- Ordering between pipe and aux writes to the same register is not checked here. The hazard unit owns it.

## Timing
- portD_* are registered. A request granted in cycle N appears on portD_* in cycle N+1 for exactly one cycle.
- A pipe write has 1 cycle latency.
- portD_key and portD_value follow the granted source even when portD_enable=0. When nothing is granted they hold the last value.
- pipe_stall is registered. It asserts the cycle after FORCE is entered.
- Reset values: portD_enable=0, portD_key=0, portD_value=0, pipe_stall=0, aux_ready=1, count=0, state IDLE, wait_cnt=0.
- Reset asserted mid-operation discards queued aux entries. The aux unit re-issues them after reset.

## Configuration
- WB_ARB_STARVE_EN defined: the IDLE/WAIT/FORCE FSM and wait_cnt are present, and pipe_stall behaves as above.
- WB_ARB_STARVE_EN undefined: no FSM or counter, pipe_stall is tied 0, and aux waits for idle pipe cycles indefinitely. All other behaviour is identical.

## Test plan
- Pipe only: pipe_valid=1, dest=5, result=0xDEADBEEF in cycle N → portD_enable=1, key=5, value=0xDEADBEEF in N+1. Non-special dest=0 → portD_enable=0.
- Special: pipe_is_dest_special=1, dest=0, result=0x80 → portD_enable=1, key=0. Special with dest=3 → no write, and a queued aux entry is granted that cycle.
- Aux FIFO: push 3 aux results on consecutive cycles with pipe busy → aux_ready drops after the 2nd push, and the 3rd push is held off. After the pipe idles, writes appear in push order on consecutive cycles.
- Same-cycle push/pop with count=1 → count stays 1, and ordering is preserved.
- Starvation (macro on, MAX_WAIT=8): pipe effective every cycle, one aux entry queued → pipe_stall=1 eight cycles after the FIFO becomes non-empty. Dropping pipe_valid for one cycle → aux written the next cycle, and pipe_stall deasserts the cycle after. With the macro off → pipe_stall never asserts.
- Reset: assert reset with 2 aux entries queued and pipe_stall=1 → all outputs at reset values immediately, aux_ready=1, and no stale write after release.
